// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register pending
// (scoreboard) bit. Register 0 always reads as zero. Reads are combinational.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears registers and pending bits)
//   rAddress   NUM_RD read addresses, port i at [i*AW +: AW]
//   rdata      NUM_RD read data words, port i at [i*XLEN +: XLEN]
//   rbusy      pending bit of each read port's addressed register
//   wen        writeback enable (writes data, clears pending)
//   wAddress   writeback destination
//   wdata      writeback data
//   iss_en     issue strobe (sets pending on iss_addr)
//   iss_addr   destination of the issuing instruction
//   busy_vec   registered pending bits, bit 0 always 0
//   any_busy   OR of busy_vec
//
// Optional build macro: REGFILE_WR_BYPASS_EN
//   When defined, a read of the register being written this cycle returns
//   wdata combinationally. Its rbusy reads 0 unless the same register is
//   also being issued this cycle.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*$clog2(NREGS)-1:0] rAddress,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     wen,
  input  logic [$clog2(NREGS)-1:0] wAddress,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     iss_en,
  input  logic [$clog2(NREGS)-1:0] iss_addr,
  output logic [NREGS-1:0]         busy_vec,
  output logic                     any_busy
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = wen && (wAddress != '0);
  assign iss_ok = iss_en && (iss_addr != '0);

  // Register 0 is never written and its pending bit is never set, so it
  // stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        regs[wAddress]   <= wdata;
        busy_q[wAddress] <= 1'b0;
      end
      // Placed after the write clear so that a same-cycle issue to the
      // retiring destination keeps the register pending.
      if (iss_ok) begin
        busy_q[iss_addr] <= 1'b1;
      end
    end
  end

  assign busy_vec = busy_q;
  assign any_busy = |busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = rAddress[i*AW +: AW];

    always_comb begin
      rd = regs[ra];
      rb = busy_q[ra];
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
`ifdef REGFILE_WR_BYPASS_EN
      // Gated by rst_n so that reads stay zero while reset is held.
      else if (rst_n && wen && (ra == wAddress)) begin
        rd = wdata;
        rb = iss_en && (iss_addr == ra);
      end
`endif
    end

    assign rdata[i*XLEN +: XLEN] = rd;
    assign rbusy[i]              = rb;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  // DUT A: default parameters
  logic [9:0]  rAddress;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        wen;
  logic [4:0]  wAddress;
  logic [31:0] wdata;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [31:0] busy_vec;
  logic        any_busy;

  // DUT B: XLEN=64, NREGS=16, NUM_RD=3
  logic [11:0]  rAddress_b;
  logic [191:0] rdata_b;
  logic [2:0]   rbusy_b;
  logic         wen_b;
  logic [3:0]   wAddress_b;
  logic [63:0]  wdata_b;
  logic         iss_en_b;
  logic [3:0]   iss_addr_b;
  logic [15:0]  busy_vec_b;
  logic         any_busy_b;

  regfile_sb dut_a (
    .clk(clk), .rst_n(rst_n),
    .rAddress(rAddress), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .wAddress(wAddress), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec), .any_busy(any_busy)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NUM_RD(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rAddress(rAddress_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen(wen_b), .wAddress(wAddress_b), .wdata(wdata_b),
    .iss_en(iss_en_b), .iss_addr(iss_addr_b),
    .busy_vec(busy_vec_b), .any_busy(any_busy_b)
  );

  always #5 clk = ~clk;

  // kind: 0 rdata A, 1 rbusy A, 2 busy_vec A, 3 any_busy A, 4 rdata B, 5 busy_vec B
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic push(input string name, input int kind, input int port, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [4:0] a);
    rAddress[p*5 +: 5] = a;
  endtask

  task automatic set_ra_b(input int p, input logic [3:0] a);
    rAddress_b[p*4 +: 4] = a;
  endtask

  // Monitor: outputs are combinational/registered and always presented, so
  // every pending expectation is checked on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = 64'(rdata[e.port*32 +: 32]);
        1:       act = 64'(rbusy[e.port]);
        2:       act = 64'(busy_vec);
        3:       act = 64'(any_busy);
        4:       act = rdata_b[e.port*64 +: 64];
        default: act = 64'(busy_vec_b);
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rAddress = '0; wen = 1'b0; wAddress = '0; wdata = '0; iss_en = 1'b0; iss_addr = '0;
    rAddress_b = '0; wen_b = 1'b0; wAddress_b = '0; wdata_b = '0; iss_en_b = 1'b0; iss_addr_b = '0;
    #1;
    set_ra(0, 5);
    push("rst_rdata", 0, 0, 64'h0);
    push("rst_busy_vec", 2, 0, 64'h0);
    push("rst_any_busy", 3, 0, 64'h0);
    step();
    step();
    rst_n = 1'b1;

    // write reg5, then reset while a write and issue are pending
    step();
    wen = 1; wAddress = 5; wdata = 32'hDEADBEEF; set_ra(0, 5);
    push("wr5_same_cycle", 0, 0, BYP ? 64'hDEADBEEF : 64'h0);
    step();
    wen = 0;
    push("wr5_next", 0, 0, 64'hDEADBEEF);
    step();
    rst_n = 0; wen = 1; wAddress = 5; wdata = 32'h1; iss_en = 1; iss_addr = 5;
    push("midrst_rdata", 0, 0, 64'h0);
    push("midrst_rbusy", 1, 0, 64'h0);
    push("midrst_busy_vec", 2, 0, 64'h0);
    push("midrst_any", 3, 0, 64'h0);
    step();
    push("midrst_hold_rdata", 0, 0, 64'h0);
    push("midrst_hold_busy", 2, 0, 64'h0);
    step();
    rst_n = 1; wen = 0; iss_en = 0;
    push("postrst_rdata", 0, 0, 64'h0);
    push("postrst_busy", 2, 0, 64'h0);

    // x0 protection
    step();
    wen = 1; wAddress = 0; wdata = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; set_ra(0, 0);
    push("x0_rdata_same", 0, 0, 64'h0);
    push("x0_rbusy_same", 1, 0, 64'h0);
    step();
    wen = 0; iss_en = 0;
    push("x0_rdata", 0, 0, 64'h0);
    push("x0_rbusy", 1, 0, 64'h0);
    push("x0_busy_vec", 2, 0, 64'h0);
    push("x0_any", 3, 0, 64'h0);

    // scoreboard lifecycle on reg7
    step();
    iss_en = 1; iss_addr = 7; set_ra(1, 7);
    push("iss7_rbusy_same", 1, 1, 64'h0);
    step();
    iss_en = 0;
    push("iss7_rbusy", 1, 1, 64'h1);
    push("iss7_busy_vec", 2, 0, 64'h80);
    push("iss7_any", 3, 0, 64'h1);
    step();
    wen = 1; wAddress = 7; wdata = 32'h12345678;
    push("wb7_rdata_same", 0, 1, BYP ? 64'h12345678 : 64'h0);
    push("wb7_rbusy_same", 1, 1, BYP ? 64'h0 : 64'h1);
    step();
    wen = 0;
    push("wb7_rdata", 0, 1, 64'h12345678);
    push("wb7_rbusy", 1, 1, 64'h0);
    push("wb7_any", 3, 0, 64'h0);

    // collision on reg9
    step();
    wen = 1; wAddress = 9; wdata = 32'hA5A5A5A5; iss_en = 1; iss_addr = 9; set_ra(0, 9);
    push("col9_rdata_same", 0, 0, BYP ? 64'hA5A5A5A5 : 64'h0);
    push("col9_rbusy_same", 1, 0, BYP ? 64'h1 : 64'h0);
    step();
    wen = 0; iss_en = 0;
    push("col9_rdata", 0, 0, 64'hA5A5A5A5);
    push("col9_rbusy", 1, 0, 64'h1);
    push("col9_busy_vec", 2, 0, 64'h200);

    // issue and write to different registers
    step();
    iss_en = 1; iss_addr = 4; wen = 1; wAddress = 9; wdata = 32'h1111;
    push("diff_busy_same", 2, 0, 64'h200);
    step();
    wen = 0;
    // iss_en stays high: re-issue reg4 while already busy
    push("diff_busy_vec", 2, 0, 64'h10);
    push("diff_rdata9", 0, 0, 64'h1111);
    push("diff_rbusy9", 1, 0, 64'h0);
    step();
    iss_en = 0;
    push("reiss_busy_vec", 2, 0, 64'h10);
    step();
    wen = 1; wAddress = 4; wdata = 32'h44;
    step();
    wen = 0;
    push("reiss_clear_busy", 2, 0, 64'h0);
    push("reiss_clear_any", 3, 0, 64'h0);

    // write to a non-busy register while reading it
    step();
    wen = 1; wAddress = 3; wdata = 32'h55; set_ra(1, 3);
    push("wr3_rdata_same", 0, 1, BYP ? 64'h55 : 64'h0);
    push("wr3_rbusy_same", 1, 1, 64'h0);
    step();
    wen = 0;
    push("wr3_rdata", 0, 1, 64'h55);
    push("wr3_rbusy", 1, 1, 64'h0);
    push("wr3_busy_vec", 2, 0, 64'h0);

    // reset with a pending register, then a late writeback
    step();
    iss_en = 1; iss_addr = 12;
    step();
    iss_en = 0;
    push("pend12_busy_vec", 2, 0, 64'h1000);
    step();
    rst_n = 0;
    push("rst12_busy_vec", 2, 0, 64'h0);
    push("rst12_any", 3, 0, 64'h0);
    push("rst12_rdata3", 0, 1, 64'h0);
    step();
    rst_n = 1; wen = 1; wAddress = 12; wdata = 32'hC; set_ra(0, 12);
    step();
    wen = 0;
    push("late12_rdata", 0, 0, 64'hC);
    push("late12_rbusy", 1, 0, 64'h0);
    push("late12_busy_vec", 2, 0, 64'h0);

    // wide configuration: three ports
    step();
    wen_b = 1; wAddress_b = 15; wdata_b = 64'h0123456789ABCDEF;
    set_ra_b(0, 15); set_ra_b(1, 15); set_ra_b(2, 15);
    step();
    wAddress_b = 2; wdata_b = 64'hFEDCBA9876543210;
    push("b_p0_r15", 4, 0, 64'h0123456789ABCDEF);
    push("b_p1_r15", 4, 1, 64'h0123456789ABCDEF);
    push("b_p2_r15", 4, 2, 64'h0123456789ABCDEF);
    step();
    wen_b = 0; set_ra_b(1, 0); set_ra_b(2, 2);
    push("b_p0_r15b", 4, 0, 64'h0123456789ABCDEF);
    push("b_p1_r0", 4, 1, 64'h0);
    push("b_p2_r2", 4, 2, 64'hFEDCBA9876543210);
    push("b_busy_vec", 5, 0, 64'h0);

    step();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      n_miss++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
